// File: rtl/pb_debouncer.sv
// Push-button debouncer: two-flop synchronizer followed by a four-state
// qualification FSM that accepts a level only after DEBOUNCE_CYCLES+1 stable samples.
module pb_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic pb_in,
  output logic db_level,
  output logic db_busy
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // state     | meaning
  // IDLE_LOW  | settled low, watching for a press
  // WAIT_HIGH | sync2 high, qualifying a press
  // IDLE_HIGH | settled high, watching for a release
  // WAIT_LOW  | sync2 low, qualifying a release
  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b11,
    WAIT_LOW  = 2'b10
  } state_t;

  logic          r_sync1;
  logic          r_sync2;
  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_next_cnt;
  logic          w_cnt_done;
  logic          w_next_level;
  logic          w_next_busy;
  logic          r_level;
  logic          r_busy;

  assign w_cnt_done = (r_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pb_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE_LOW;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_level <= w_next_level;
      r_busy  <= w_next_busy;
    end
  end

  always_comb begin
    w_next_state = IDLE_LOW;
    w_next_cnt   = '0;
    case (r_state)
      IDLE_LOW: begin
        w_next_state = r_sync2 ? WAIT_HIGH : IDLE_LOW;
      end
      WAIT_HIGH: begin
        if (!r_sync2) begin
          w_next_state = IDLE_LOW;
        end else if (w_cnt_done) begin
          w_next_state = IDLE_HIGH;
        end else begin
          w_next_state = WAIT_HIGH;
          w_next_cnt   = r_cnt + CW'(1);
        end
      end
      IDLE_HIGH: begin
        w_next_state = r_sync2 ? IDLE_HIGH : WAIT_LOW;
      end
      WAIT_LOW: begin
        if (r_sync2) begin
          w_next_state = IDLE_HIGH;
        end else if (w_cnt_done) begin
          w_next_state = IDLE_LOW;
        end else begin
          w_next_state = WAIT_LOW;
          w_next_cnt   = r_cnt + CW'(1);
        end
      end
      default: begin
        w_next_state = IDLE_LOW;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it,
  // so they track the state exactly and never glitch.
  always_comb begin
    w_next_level = (w_next_state == IDLE_HIGH) || (w_next_state == WAIT_LOW);
    w_next_busy  = (w_next_state == WAIT_HIGH) || (w_next_state == WAIT_LOW);
  end

  assign db_level = r_level;
  assign db_busy  = r_busy;

endmodule
